// File: rtl/protocol_pkg.sv
// Shared types and defaults for the smart-LED pulse decoder.
package protocol_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_HIGH,
    S_STUCK
  } state_t;

  localparam int unsigned NUM_BITS               = 32;
  localparam int unsigned DEFAULT_THRESHOLD_CYCLES = 24;
  localparam int unsigned DEFAULT_GAP_CYCLES     = 2000;
  localparam int unsigned DEFAULT_CNT_W          = 12;

endpackage

// File: rtl/protocol_pulse_decoder_if.sv
// LED line in, decoded bit stream and regenerated line out.
interface protocol_pulse_decoder_if;

  logic din;
  logic bit_data;
  logic bit_strobe;
  logic store;
  logic dout;
  logic error;

  modport master (
    output din,
    input  bit_data,
    input  bit_strobe,
    input  store,
    input  dout,
    input  error
  );

  modport slave (
    input  din,
    output bit_data,
    output bit_strobe,
    output store,
    output dout,
    output error
  );

endinterface

// File: rtl/protocol_sync.sv
// Two-flop synchronizer for the asynchronous LED line plus an edge register.
module protocol_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic din_d;

  // Synchronize din and keep one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/protocol_pulse_decoder.sv
// Pulse-width decoder: consumes the first NUM_BITS bits of each frame,
// forwards the rest on dout, and flags end-of-frame and a stuck-high line.
module protocol_pulse_decoder #(
  parameter int unsigned THRESHOLD_CYCLES = protocol_pkg::DEFAULT_THRESHOLD_CYCLES,
  parameter int unsigned GAP_CYCLES       = protocol_pkg::DEFAULT_GAP_CYCLES,
  parameter int unsigned CNT_W            = protocol_pkg::DEFAULT_CNT_W,
  parameter int unsigned NUM_BITS         = protocol_pkg::NUM_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  protocol_pulse_decoder_if.slave  bus
);

  import protocol_pkg::*;

  localparam int unsigned BC_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] GAP  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESHOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [BC_W-1:0]  FULL = BC_W'(NUM_BITS);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BC_W-1:0]   bit_count, bit_count_n;
  logic              eof_done, eof_done_n;
  logic              eof;
  logic              fwd;
  logic              din_s, rise, fall;
  logic              data_n, strobe_n, store_n, error_n, dout_n;
  logic              data_q, strobe_q, store_q, error_q, dout_q;

  protocol_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  // State, pulse counter and frame bit counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOW;
      cnt       <= '0;
      bit_count <= '0;
      eof_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_count <= bit_count_n;
      eof_done  <= eof_done_n;
    end
  end

  // Next-state decode: time each level, classify pulses, detect gap and stuck line.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_count_n = bit_count;
    eof_done_n  = eof_done;
    eof         = 1'b0;
    data_n      = 1'b0;
    strobe_n    = 1'b0;
    store_n     = 1'b0;
    error_n     = 1'b0;
    unique case (state)
      S_LOW: begin
        if (cnt != GAP) cnt_n = cnt + 1'b1;
        // eof_done keeps the saturated count from re-firing end-of-frame
        if (cnt == GAP && !eof_done) begin
          eof         = 1'b1;
          eof_done_n  = 1'b1;
          store_n     = (bit_count == FULL);
          bit_count_n = '0;
        end
        if (rise) begin
          state_n = S_HIGH;
          cnt_n   = ONE;
        end
      end
      S_HIGH: begin
        cnt_n = cnt + 1'b1;
        if (fall) begin
          state_n    = S_LOW;
          cnt_n      = ONE;
          eof_done_n = 1'b0;
          if (bit_count < FULL) begin
            strobe_n    = 1'b1;
            data_n      = (cnt >= THR);
            bit_count_n = bit_count + 1'b1;
          end
        end else if (cnt == GAP) begin
          error_n     = 1'b1;
          bit_count_n = '0;
          cnt_n       = '0;
          state_n     = S_STUCK;
        end
      end
      S_STUCK: begin
        if (fall) begin
          state_n    = S_LOW;
          cnt_n      = ONE;
          eof_done_n = 1'b0;
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
      end
    endcase
    // End-of-frame closes forwarding in the same cycle, so a next-frame rise
    // landing exactly on the gap boundary is not leaked onto dout.
    fwd    = (bit_count == FULL) && !eof;
    dout_n = fwd & din_s;
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
      store_q  <= 1'b0;
      error_q  <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      data_q   <= data_n;
      strobe_q <= strobe_n;
      store_q  <= store_n;
      error_q  <= error_n;
      dout_q   <= dout_n;
    end
  end

  assign bus.bit_data   = data_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.store      = store_q;
  assign bus.error      = error_q;
  assign bus.dout       = dout_q;

endmodule

// File: tb/tb_protocol_pulse_decoder.sv
// Self-checking bench: pulse-list reference model versus observed output events.
module tb_protocol_pulse_decoder;

  localparam int unsigned TH  = 24;
  localparam int unsigned GAP = 2000;
  localparam int unsigned NB  = 32;
  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  protocol_pulse_decoder_if bus ();

  protocol_pulse_decoder #(
    .THRESHOLD_CYCLES (TH),
    .GAP_CYCLES       (GAP),
    .CNT_W            (12),
    .NUM_BITS         (NB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  // observed events
  bit          got_bits[$];
  int unsigned got_store[$], got_err[$], got_dw[$], got_dr[$];
  // expected events from the model
  bit          exp_bits[$];
  int unsigned exp_store[$], exp_err[$], exp_dw[$], exp_dr[$];

  int unsigned run = 0;
  int unsigned both_cnt = 0;
  int unsigned mcount = 0;

  // Output monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (bus.bit_strobe) got_bits.push_back(bus.bit_data);
      if (bus.store) got_store.push_back(cyc);
      if (bus.error) got_err.push_back(cyc);
      if (bus.store && bus.bit_strobe) both_cnt++;
      if (bus.dout) begin
        if (run == 0) got_dr.push_back(cyc);
        run++;
      end else if (run != 0) begin
        got_dw.push_back(run);
        run = 0;
      end
    end
  end

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold din at level v for n sampling edges; c returns the cycle it was set.
  task automatic hold(logic v, int unsigned n, output int unsigned c);
    bus.din = v;
    c = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One high pulse of h cycles then l low cycles, with model update.
  task automatic pulse(int unsigned h, int unsigned l);
    int unsigned rc, fc;
    hold(1'b1, h, rc);
    if (h >= GAP) begin
      exp_err.push_back(rc + GAP + LAT);
      mcount = 0;
    end else if (mcount < NB) begin
      exp_bits.push_back(h >= TH);
      mcount++;
    end else begin
      exp_dw.push_back(h);
      exp_dr.push_back(rc + LAT);
      mcount++;
    end
    hold(1'b0, l, fc);
    if (l >= GAP) begin
      if (mcount >= NB) exp_store.push_back(fc + GAP + LAT);
      mcount = 0;
    end
  endtask

  task automatic rand_frame(int unsigned nbits, int unsigned last_low);
    int unsigned h;
    for (int i = 0; i < int'(nbits); i++) begin
      h = ($urandom_range(1, 0) == 1) ? $urandom_range(60, TH) : $urandom_range(TH - 1, 3);
      pulse(h, (i == int'(nbits) - 1) ? last_low : $urandom_range(40, 3));
    end
  endtask

  task automatic clear_all();
    got_bits.delete(); got_store.delete(); got_err.delete(); got_dw.delete(); got_dr.delete();
    exp_bits.delete(); exp_store.delete(); exp_err.delete(); exp_dw.delete(); exp_dr.delete();
  endtask

  task automatic check_all(string name);
    int unsigned c;
    hold(bus.din, 10, c);
    chk({name, ".nbits"}, got_bits.size(), exp_bits.size());
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
      chk($sformatf("%s.bit%0d", name, i), got_bits[i], exp_bits[i]);
    chk({name, ".nstore"}, got_store.size(), exp_store.size());
    for (int i = 0; i < got_store.size() && i < exp_store.size(); i++)
      chk($sformatf("%s.store_cyc%0d", name, i), got_store[i], exp_store[i]);
    chk({name, ".nerror"}, got_err.size(), exp_err.size());
    for (int i = 0; i < got_err.size() && i < exp_err.size(); i++)
      chk($sformatf("%s.error_cyc%0d", name, i), got_err[i], exp_err[i]);
    chk({name, ".ndout"}, got_dr.size(), exp_dr.size());
    for (int i = 0; i < got_dr.size() && i < exp_dr.size(); i++)
      chk($sformatf("%s.dout_rise%0d", name, i), got_dr[i], exp_dr[i]);
    for (int i = 0; i < got_dw.size() && i < exp_dw.size(); i++)
      chk($sformatf("%s.dout_width%0d", name, i), got_dw[i], exp_dw[i]);
    clear_all();
  endtask

  task automatic chk_outputs_zero(string name);
    chk({name, ".bit_data"},   bus.bit_data,   0);
    chk({name, ".bit_strobe"}, bus.bit_strobe, 0);
    chk({name, ".store"},      bus.store,      0);
    chk({name, ".dout"},       bus.dout,       0);
    chk({name, ".error"},      bus.error,      0);
  endtask

  initial begin
    int unsigned c;
    bus.din = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // alternating 30/10 highs, exact 2000-cycle final low
    for (int i = 0; i < 32; i++) pulse((i % 2 == 0) ? 30 : 10, (i == 31) ? GAP : 40);
    check_all("alt");

    rand_frame(40, 2100);
    check_all("f40");

    rand_frame(20, 2100);
    check_all("f20");
    rand_frame(32, 2100);
    check_all("f32");

    // 1999-cycle gap continues the frame; exact 2000 with a new rise ends it
    rand_frame(16, GAP - 1);
    rand_frame(16, GAP);
    pulse(30, 2100);
    check_all("gap");

    for (int i = 0; i < 32; i++) pulse((i % 2 == 0) ? TH - 1 : TH, (i == 31) ? 2100 : 20);
    check_all("thr");

    rand_frame(10, 30);
    pulse(2500, 2100);
    check_all("stuck");
    rand_frame(32, 2100);
    check_all("after_stuck");

    // reset in the middle of a forwarded pulse
    rand_frame(33, 20);
    check_all("pre_rst");
    hold(1'b1, 10, c);
    chk("fwd_before_rst", bus.dout, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("mid_rst");
    bus.din = 1'b0;
    clear_all();
    mcount = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rand_frame(32, 2100);
    check_all("post_rst");

    chk("store_strobe_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
